// File: rtl/ahb_manager_pack.sv
// Shared AHB-Lite bus types plus the SRAM subordinate state encoding.
// Also holds the transfer legality check used when an address phase is sampled.
package ahb_manager_pack;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    INCR   = 3'b001,
    INCR4  = 3'b011,
    INCR8  = 3'b101,
    INCR16 = 3'b111
  } t_hburst;

  typedef enum logic [2:0] {
    SZ_BYTE   = 3'd0,
    SZ_HALF   = 3'd1,
    SZ_WORD   = 3'd2,
    SZ_DWORD  = 3'd3,
    SZ_4WORD  = 3'd4,
    SZ_8WORD  = 3'd5,
    SZ_16WORD = 3'd6,
    SZ_32WORD = 3'd7
  } t_hsize;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } t_hresp;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } t_sub_state;

  // In range, naturally aligned, and no wider than the data bus.
  function automatic logic xfer_legal(input logic [31:0] addr, input t_hsize size,
                                      input int unsigned mem_bytes,
                                      input int unsigned data_wdt);
    logic [31:0] mask;
    mask = (32'd1 << size) - 32'd1;
    return (addr < mem_bytes) && ((addr & mask) == 32'd0) && ((32'd8 << size) <= data_wdt);
  endfunction

endpackage

// File: rtl/ahb_sub_lane_decode.sv
// Byte-lane enables for a little-endian transfer of 2^hsize bytes
// starting at lane addr_lo_i.
module ahb_sub_lane_decode
  import ahb_manager_pack::*;
#(
  parameter int DATA_WDT = 32,
  localparam int LANES   = DATA_WDT / 8,
  localparam int LANE_AW = $clog2(LANES)
) (
  input  logic [LANE_AW-1:0] addr_lo_i,
  input  t_hsize             hsize_i,
  output logic [LANES-1:0]   be_o
);

  int lane_lo;
  int lane_hi;

  assign lane_lo = int'(addr_lo_i);
  assign lane_hi = lane_lo + (1 << hsize_i);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_be
    assign be_o[gi] = (gi >= lane_lo) && (gi < lane_hi);
  end

endmodule

// File: rtl/ahb_subordinate_sram.sv
// AHB-Lite SRAM subordinate with optional wait states and a two-cycle ERROR
// response; storage is one byte-wide array per lane, read combinationally.
module ahb_subordinate_sram
  import ahb_manager_pack::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int MEM_BYTES   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  t_hburst             i_hburst,
  input  t_hsize              i_hsize,
  input  logic                i_hwrite,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output t_hresp              o_hresp
);

  localparam int LANES   = DATA_WDT / 8;
  localparam int LANE_AW = $clog2(LANES);
  localparam int ADDR_W  = $clog2(MEM_BYTES);
  localparam int DEPTH   = MEM_BYTES / LANES;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  t_sub_state          state_q, state_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  t_hsize              hsize_q, hsize_d;
  logic                write_q, write_d;
  logic                addr_accept;
  logic                addr_legal;
  logic                commit;
  logic [LANES-1:0]    lane_be;
  logic [DATA_WDT-1:0] rd_word;
  logic [ADDR_W-LANE_AW-1:0] word_idx;
  logic                unused_burst;

  assign unused_burst = ^i_hburst;
  assign addr_accept  = i_hsel && i_hready && (i_htrans == NONSEQ || i_htrans == SEQ);
  assign addr_legal   = xfer_legal(i_haddr, i_hsize, MEM_BYTES, DATA_WDT);

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      hsize_q    <= SZ_BYTE;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      hsize_q    <= hsize_d;
      write_q    <= write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    hsize_d    = hsize_q;
    write_d    = write_q;
    o_hready   = 1'b1;
    o_hresp    = OKAY;
    case (state_q)
      ST_WAIT: begin
        o_hready   = 1'b0;
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q <= 3'd1) state_d = ST_XFER;
      end
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = ERROR;
        state_d  = ST_ERR2;
      end
      default: begin
        // IDLE, XFER and ERR2 all complete a data phase, so the next address phase is sampled here.
        if (state_q == ST_ERR2) o_hresp = ERROR;
        state_d = ST_IDLE;
        if (addr_accept) begin
          addr_d  = i_haddr[ADDR_W-1:0];
          hsize_d = i_hsize;
          write_d = i_hwrite;
          if (!addr_legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_XFER;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
    endcase
  end

  assign commit   = (state_q == ST_XFER) && write_q && !i_hreset;
  assign word_idx = addr_q[ADDR_W-1:LANE_AW];

  ahb_sub_lane_decode #(
    .DATA_WDT (DATA_WDT)
  ) u_lane_decode (
    .addr_lo_i (addr_q[LANE_AW-1:0]),
    .hsize_i   (hsize_q),
    .be_o      (lane_be)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge i_hclk) begin
      if (commit && lane_be[gi]) mem_q[word_idx] <= i_hwdata[gi*8 +: 8];
    end

    assign rd_word[gi*8 +: 8] = mem_q[word_idx];
  end

  assign o_hrdata = (state_q == ST_XFER && !write_q) ? rd_word : '0;

endmodule
